rv_mc_controller_hs: RTL and testbench



---
 rtl/rv_mc_controller_hs_if.sv | 25 ++
 rtl/rv_mc_controller_hs.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_rv_mc_controller_hs.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mc_controller_hs_if.sv
// Unified memory port between the multicycle controller and the memory.
// The controller raises mem_req with AdrSrc selecting the address source;
// the memory answers with mem_ready in the cycle the access completes.
interface rv_mc_controller_hs_if;
    logic mem_req;
    logic mem_ready;
    logic MemWrite;
    logic AdrSrc;

    // Controller side: drives the request, strobe and address select.
    modport master (
        output mem_req,
        output MemWrite,
        output AdrSrc,
        input  mem_ready
    );

    // Memory side: observes the request and completes it with mem_ready.
    modport slave (
        input  mem_req,
        input  MemWrite,
        input  AdrSrc,
        output mem_ready
    );
endinterface

// File: rtl/rv_mc_controller_hs.sv
// Multicycle RV32I control unit with a ready-handshaked unified memory port.
// Memory accesses may take any number of wait states; a watchdog halts the
// core with bus_err if mem_ready never arrives. Illegal opcodes, illegal
// funct3 values and ECALL park the unit in an absorbing HALT state.
// The state register is the only FSM storage; control outputs are decoded
// from it. FETCH and MEMWRITE use mem_ready directly, so their write
// enables fire in the completion cycle itself.
module rv_mc_controller_hs #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ZERO,
    input  logic [6:0]       OpCode,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    rv_mc_controller_hs_if.master mem,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic             RegWrite,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    // Opcodes recognised by the dispatcher.
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // ALU operation encodings.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    // Operand / result / immediate select encodings.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;
    localparam logic [2:0] IMM_I      = 3'b000;
    localparam logic [2:0] IMM_S      = 3'b001;
    localparam logic [2:0] IMM_B      = 3'b010;
    localparam logic [2:0] IMM_J      = 3'b011;
    localparam logic [2:0] IMM_U      = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALRADR,
        S_JAL,
        S_LUI,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [TO_W-1:0]  r_wd;
    logic [CNT_W-1:0] r_instret;
    logic             r_busErr;

    logic             w_memReq;
    logic             w_timeout;
    logic             w_retire;
    logic [2:0]       w_execAlu;
    logic             w_execOk;
    logic [2:0]       w_brAlu;
    logic             w_brTaken;
    logic             w_brOk;
    logic             w_unused;

    // Only bit 5 of funct7 matters (add vs sub); the rest is intentionally ignored.
    assign w_unused = ^{f7[6], f7[4:0]};

    // States that hold a memory access open.
    assign w_memReq = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);

    // The access has waited TIMEOUT-1 cycles already and this cycle is yet another miss.
    assign w_timeout = w_memReq && !mem.mem_ready && (r_wd == TO_W'(TIMEOUT - 1));

    // An instruction retires when one of its final states hands control back to FETCH.
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB)  || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB)  || (r_state == S_BRANCH)   ||
                       (r_state == S_LUI));

    assign halted  = (r_state == S_HALT);
    assign bus_err = r_busErr;
    assign instret = r_instret;

    // ALU operation for R/I-type execution; unsupported funct3 values are flagged illegal.
    always_comb begin
        w_execAlu = ALU_ADD;
        w_execOk  = 1'b1;
        case (f3)
            3'b000:  w_execAlu = ((r_state == S_EXECR) && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b100:  w_execAlu = ALU_XOR;
            3'b110:  w_execAlu = ALU_OR;
            3'b111:  w_execAlu = ALU_AND;
            3'b010:  w_execAlu = ALU_SLT;
            default: w_execOk  = 1'b0;
        endcase
    end

    // Branch compare operation and taken decision from funct3 and the ALU zero flag.
    always_comb begin
        w_brAlu   = ALU_SUB;
        w_brTaken = 1'b0;
        w_brOk    = 1'b1;
        case (f3)
            3'b000: begin
                w_brAlu   = ALU_SUB;
                w_brTaken = ZERO;
            end
            3'b001: begin
                w_brAlu   = ALU_SUB;
                w_brTaken = !ZERO;
            end
            3'b100: begin
                w_brAlu   = ALU_SLT;
                w_brTaken = !ZERO;
            end
            3'b101: begin
                w_brAlu   = ALU_SLT;
                w_brTaken = ZERO;
            end
            default: w_brOk = 1'b0;
        endcase
    end

    // Control decode of the current state and next-state selection; a watchdog expiry overrides both.
    always_comb begin
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUControl   = ALU_ADD;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_B;
        ImmSrc       = IMM_I;
        mem.mem_req  = 1'b0;
        mem.MemWrite = 1'b0;
        mem.AdrSrc   = 1'b0;
        w_next       = r_state;

        case (r_state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                ALUSrcA     = SRCA_PC;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURES;
                if (mem.mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (OpCode == OP_JAL) ? IMM_J : IMM_B;
                case (OpCode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRNCH:          w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALRADR;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                if (OpCode == OP_STORE) begin
                    ImmSrc = IMM_S;
                    w_next = S_MEMWRITE;
                end else begin
                    ImmSrc = IMM_I;
                    w_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem.mem_req = 1'b1;
                mem.AdrSrc  = 1'b1;
                if (mem.mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem.mem_req = 1'b1;
                mem.AdrSrc  = 1'b1;
                if (mem.mem_ready) begin
                    mem.MemWrite = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = (r_state == S_EXECI) ? SRCB_IMM : SRCB_B;
                ImmSrc     = IMM_I;
                ALUControl = w_execAlu;
                w_next     = w_execOk ? S_ALUWB : S_HALT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_A;
                ALUSrcB   = SRCB_B;
                ResultSrc = RES_ALUOUT;
                if (w_brOk) begin
                    ALUControl = w_brAlu;
                    PCWrite    = w_brTaken;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_JALRADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                w_next  = S_JAL;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase

        if (w_timeout) begin
            PCWrite      = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            mem.MemWrite = 1'b0;
            w_next       = S_HALT;
        end
    end

    // State register, wait-state watchdog, sticky bus error flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_wd      <= '0;
            r_instret <= '0;
            r_busErr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_timeout) begin
                r_busErr <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if ((w_next != r_state) || mem.mem_ready) begin
                r_wd <= '0;
            end else if (w_memReq) begin
                r_wd <= r_wd + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_mc_controller_hs.sv
// Self-checking bench for rv_mc_controller_hs: a per-cycle vector table walks
// a program of every instruction class from reset, then hand-written
// sequences exercise the watchdog timeout and a reset in the middle of a store.
module tb_rv_mc_controller_hs;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  fn3;
        logic [6:0]  fn7;
        logic        zero;
        logic        rdy;
        logic [19:0] ctl;
        logic [31:0] ins;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ZERO;
    logic [6:0]  OpCode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        PCWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [2:0]  ALUControl;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic        RegWrite;
    logic        halted;
    logic        bus_err;
    logic [31:0] instret;
    logic [19:0] actCtl;

    vec_t vecs[$];
    int   nTotal;
    int   nBad;

    logic [19:0] cFetch, cFetchW, cDec, cDecJ, cAluWB, cMemRd, cMemWb;
    logic [19:0] cMemAdrL, cMemAdrS, cMemWrW, cMemWr, cJal, cHalt, cHaltErr;

    rv_mc_controller_hs_if memIf ();

    rv_mc_controller_hs #(
        .TO_W    (8),
        .TIMEOUT (4),
        .CNT_W   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ZERO       (ZERO),
        .OpCode     (OpCode),
        .f3         (f3),
        .f7         (f7),
        .mem        (memIf),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .halted     (halted),
        .bus_err    (bus_err),
        .instret    (instret)
    );

    // All control outputs packed in one word so a cycle is compared in one go.
    assign actCtl = {PCWrite, memIf.AdrSrc, memIf.MemWrite, IRWrite, ResultSrc, ALUControl,
                     ALUSrcA, ALUSrcB, ImmSrc, RegWrite, memIf.mem_req, halted, bus_err};

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds an expected control word in the same field order as actCtl.
    function automatic logic [19:0] c(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [2:0] alu, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] imm,
                                      input logic rw, input logic req, input logic hlt,
                                      input logic be);
        return {pcw, adr, mw, irw, rs, alu, sa, sb, imm, rw, req, hlt, be};
    endfunction

    task automatic addv(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic z, input logic r, input logic [19:0] ctl,
                        input logic [31:0] ins);
        vec_t v;
        v.op   = op;
        v.fn3  = fn3;
        v.fn7  = fn7;
        v.zero = z;
        v.rdy  = r;
        v.ctl  = ctl;
        v.ins  = ins;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] fn3,
                                 input logic [6:0] fn7, input logic z, input logic r);
        OpCode          = op;
        f3              = fn3;
        f7              = fn7;
        ZERO            = z;
        memIf.mem_ready = r;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                               input logic [31:0] exp);
        nTotal++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s[%0d]: got %b want %b", name, idx, act, exp);
        end
    endtask

    initial begin
        nTotal = 0;
        nBad   = 0;
        rst    = 1'b0;
        applyStimulus(7'h00, 3'b000, 7'h00, N, N);

        cFetch   = c(Y,N,N,Y, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, N,Y,N,N);
        cFetchW  = c(N,N,N,N, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, N,Y,N,N);
        cDec     = c(N,N,N,N, 2'b00, 3'b000, 2'b01, 2'b01, 3'b010, N,N,N,N);
        cDecJ    = c(N,N,N,N, 2'b00, 3'b000, 2'b01, 2'b01, 3'b011, N,N,N,N);
        cAluWB   = c(N,N,N,N, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, Y,N,N,N);
        cMemAdrL = c(N,N,N,N, 2'b00, 3'b000, 2'b10, 2'b01, 3'b000, N,N,N,N);
        cMemAdrS = c(N,N,N,N, 2'b00, 3'b000, 2'b10, 2'b01, 3'b001, N,N,N,N);
        cMemRd   = c(N,Y,N,N, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, N,Y,N,N);
        cMemWb   = c(N,N,N,N, 2'b01, 3'b000, 2'b00, 2'b00, 3'b000, Y,N,N,N);
        cMemWrW  = c(N,Y,N,N, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, N,Y,N,N);
        cMemWr   = c(N,Y,Y,N, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, N,Y,N,N);
        cJal     = c(Y,N,N,N, 2'b00, 3'b000, 2'b01, 2'b10, 3'b000, N,N,N,N);
        cHalt    = c(N,N,N,N, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, N,N,Y,N);
        cHaltErr = c(N,N,N,N, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, N,N,Y,Y);

        // add x3,x1,x2
        addv(OP_R, 3'b000, 7'h00, N, Y, cFetch, 0);
        addv(OP_R, 3'b000, 7'h00, N, Y, cDec, 0);
        addv(OP_R, 3'b000, 7'h00, N, Y, c(N,N,N,N,2'b00,3'b000,2'b10,2'b00,3'b000,N,N,N,N), 0);
        addv(OP_R, 3'b000, 7'h00, N, Y, cAluWB, 0);
        // sub
        addv(OP_R, 3'b000, 7'h20, N, Y, cFetch, 1);
        addv(OP_R, 3'b000, 7'h20, N, Y, cDec, 1);
        addv(OP_R, 3'b000, 7'h20, N, Y, c(N,N,N,N,2'b00,3'b001,2'b10,2'b00,3'b000,N,N,N,N), 1);
        addv(OP_R, 3'b000, 7'h20, N, Y, cAluWB, 1);
        // lw with three wait states in MEMREAD (8 cycles)
        addv(OP_LW, 3'b010, 7'h00, N, Y, cFetch, 2);
        addv(OP_LW, 3'b010, 7'h00, N, Y, cDec, 2);
        addv(OP_LW, 3'b010, 7'h00, N, Y, cMemAdrL, 2);
        addv(OP_LW, 3'b010, 7'h00, N, N, cMemRd, 2);
        addv(OP_LW, 3'b010, 7'h00, N, N, cMemRd, 2);
        addv(OP_LW, 3'b010, 7'h00, N, N, cMemRd, 2);
        addv(OP_LW, 3'b010, 7'h00, N, Y, cMemRd, 2);
        addv(OP_LW, 3'b010, 7'h00, N, Y, cMemWb, 2);
        // sw with one wait state
        addv(OP_SW, 3'b010, 7'h00, N, Y, cFetch, 3);
        addv(OP_SW, 3'b010, 7'h00, N, Y, cDec, 3);
        addv(OP_SW, 3'b010, 7'h00, N, Y, cMemAdrS, 3);
        addv(OP_SW, 3'b010, 7'h00, N, N, cMemWrW, 3);
        addv(OP_SW, 3'b010, 7'h00, N, Y, cMemWr, 3);
        // beq taken (ZERO=1)
        addv(OP_BR, 3'b000, 7'h00, Y, Y, cFetch, 4);
        addv(OP_BR, 3'b000, 7'h00, Y, Y, cDec, 4);
        addv(OP_BR, 3'b000, 7'h00, Y, Y, c(Y,N,N,N,2'b00,3'b001,2'b10,2'b00,3'b000,N,N,N,N), 4);
        // bne not taken (ZERO=1)
        addv(OP_BR, 3'b001, 7'h00, Y, Y, cFetch, 5);
        addv(OP_BR, 3'b001, 7'h00, Y, Y, cDec, 5);
        addv(OP_BR, 3'b001, 7'h00, Y, Y, c(N,N,N,N,2'b00,3'b001,2'b10,2'b00,3'b000,N,N,N,N), 5);
        // blt taken (ZERO=0)
        addv(OP_BR, 3'b100, 7'h00, N, Y, cFetch, 6);
        addv(OP_BR, 3'b100, 7'h00, N, Y, cDec, 6);
        addv(OP_BR, 3'b100, 7'h00, N, Y, c(Y,N,N,N,2'b00,3'b100,2'b10,2'b00,3'b000,N,N,N,N), 6);
        // jal
        addv(OP_JAL, 3'b000, 7'h00, N, Y, cFetch, 7);
        addv(OP_JAL, 3'b000, 7'h00, N, Y, cDecJ, 7);
        addv(OP_JAL, 3'b000, 7'h00, N, Y, cJal, 7);
        addv(OP_JAL, 3'b000, 7'h00, N, Y, cAluWB, 7);
        // jalr
        addv(OP_JALR, 3'b000, 7'h00, N, Y, cFetch, 8);
        addv(OP_JALR, 3'b000, 7'h00, N, Y, cDec, 8);
        addv(OP_JALR, 3'b000, 7'h00, N, Y, c(N,N,N,N,2'b00,3'b000,2'b10,2'b01,3'b000,N,N,N,N), 8);
        addv(OP_JALR, 3'b000, 7'h00, N, Y, cJal, 8);
        addv(OP_JALR, 3'b000, 7'h00, N, Y, cAluWB, 8);
        // lui
        addv(OP_LUI, 3'b000, 7'h00, N, Y, cFetch, 9);
        addv(OP_LUI, 3'b000, 7'h00, N, Y, cDec, 9);
        addv(OP_LUI, 3'b000, 7'h00, N, Y, c(N,N,N,N,2'b11,3'b000,2'b00,2'b00,3'b100,Y,N,N,N), 9);
        // addi with funct7[5]=1 still adds; fetch takes one wait state
        addv(OP_I, 3'b000, 7'h20, N, N, cFetchW, 10);
        addv(OP_I, 3'b000, 7'h20, N, Y, cFetch, 10);
        addv(OP_I, 3'b000, 7'h20, N, Y, cDec, 10);
        addv(OP_I, 3'b000, 7'h20, N, Y, c(N,N,N,N,2'b00,3'b000,2'b10,2'b01,3'b000,N,N,N,N), 10);
        addv(OP_I, 3'b000, 7'h20, N, Y, cAluWB, 10);
        // xori
        addv(OP_I, 3'b100, 7'h00, N, Y, cFetch, 11);
        addv(OP_I, 3'b100, 7'h00, N, Y, cDec, 11);
        addv(OP_I, 3'b100, 7'h00, N, Y, c(N,N,N,N,2'b00,3'b101,2'b10,2'b01,3'b000,N,N,N,N), 11);
        addv(OP_I, 3'b100, 7'h00, N, Y, cAluWB, 11);
        // and
        addv(OP_R, 3'b111, 7'h00, N, Y, cFetch, 12);
        addv(OP_R, 3'b111, 7'h00, N, Y, cDec, 12);
        addv(OP_R, 3'b111, 7'h00, N, Y, c(N,N,N,N,2'b00,3'b010,2'b10,2'b00,3'b000,N,N,N,N), 12);
        addv(OP_R, 3'b111, 7'h00, N, Y, cAluWB, 12);
        // or
        addv(OP_R, 3'b110, 7'h00, N, Y, cFetch, 13);
        addv(OP_R, 3'b110, 7'h00, N, Y, cDec, 13);
        addv(OP_R, 3'b110, 7'h00, N, Y, c(N,N,N,N,2'b00,3'b011,2'b10,2'b00,3'b000,N,N,N,N), 13);
        addv(OP_R, 3'b110, 7'h00, N, Y, cAluWB, 13);
        // slt
        addv(OP_R, 3'b010, 7'h00, N, Y, cFetch, 14);
        addv(OP_R, 3'b010, 7'h00, N, Y, cDec, 14);
        addv(OP_R, 3'b010, 7'h00, N, Y, c(N,N,N,N,2'b00,3'b100,2'b10,2'b00,3'b000,N,N,N,N), 14);
        addv(OP_R, 3'b010, 7'h00, N, Y, cAluWB, 14);
        // ecall halts without bus error and ignores mem_ready from then on
        addv(OP_SYS, 3'b000, 7'h00, N, Y, cFetch, 15);
        addv(OP_SYS, 3'b000, 7'h00, N, Y, cDec, 15);
        addv(OP_SYS, 3'b000, 7'h00, N, Y, cHalt, 15);
        addv(OP_SYS, 3'b000, 7'h00, N, Y, cHalt, 15);
        addv(OP_LUI, 3'b000, 7'h00, N, N, cHalt, 15);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].fn3, vecs[i].fn7, vecs[i].zero, vecs[i].rdy);
            #1;
            checkOutput("ctl", i, {12'h000, actCtl}, {12'h000, vecs[i].ctl});
            checkOutput("instret", i, instret, vecs[i].ins);
            @(negedge clk);
        end

        // Watchdog: mem_ready never arrives during FETCH.
        rst = 1'b0;
        applyStimulus(OP_R, 3'b000, 7'h00, N, N);
        #1;
        checkOutput("rstCtl", 0, {12'h000, actCtl}, {12'h000, cFetchW});
        checkOutput("rstInstret", 0, instret, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("toWait", i, {12'h000, actCtl}, {12'h000, cFetchW});
            @(negedge clk);
        end
        #1;
        checkOutput("toHalt", 0, {12'h000, actCtl}, {12'h000, cHaltErr});
        checkOutput("toInstret", 0, instret, 32'd0);
        @(negedge clk);
        memIf.mem_ready = 1'b1;
        #1;
        checkOutput("toStay", 0, {12'h000, actCtl}, {12'h000, cHaltErr});

        // Reset in the middle of a waiting store; a lui first makes instret non-zero.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(OP_LUI, 3'b000, 7'h00, N, Y);
        repeat (3) @(negedge clk);
        applyStimulus(OP_SW, 3'b010, 7'h00, N, Y);
        #1;
        checkOutput("swInstret", 0, instret, 32'd1);
        repeat (3) @(negedge clk);
        memIf.mem_ready = 1'b0;
        #1;
        checkOutput("swWait", 0, {12'h000, actCtl}, {12'h000, cMemWrW});
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRstCtl", 0, {12'h000, actCtl}, {12'h000, cFetchW});
        checkOutput("midRstInstret", 0, instret, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("postRstCtl", 0, {12'h000, actCtl}, {12'h000, cFetchW});
        memIf.mem_ready = 1'b1;
        #1;
        checkOutput("postRstFetch", 0, {12'h000, actCtl}, {12'h000, cFetch});
        @(negedge clk);
        #1;
        checkOutput("postRstDecode", 0, {12'h000, actCtl}, {12'h000, cDec});

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
